// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Shares one variable-latency memory port between instruction fetch and data
// load/store, with a request/done handshake and a timeout watchdog.
// Optional : define MEM_PORT_STATS_EN to add fetch/data/wait statistic counters.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  if_done,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  timeout_err
`ifdef MEM_PORT_STATS_EN
    ,
    output logic [15:0]           stat_fetches,
    output logic [15:0]           stat_data,
    output logic [15:0]           stat_wait
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] C_COUNT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_count;
    logic       r_grantData;

    assign stall = (if_req & ~if_done) | (d_req & ~d_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= 8'd0;
            r_grantData <= 1'b0;
            if_done     <= 1'b0;
            d_done      <= 1'b0;
            rdata       <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
`ifdef MEM_PORT_STATS_EN
            stat_fetches <= 16'd0;
            stat_data    <= 16'd0;
            stat_wait    <= 16'd0;
`endif
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Data wins contention; a pending fetch is picked up in a later IDLE
                    if (d_req) begin
                        r_grantData <= 1'b1;
                        mem_en      <= 1'b1;
                        mem_we      <= d_we;
                        mem_addr    <= d_addr;
                        mem_wdata   <= d_we ? d_wdata : '0;
                        r_count     <= 8'd0;
                        r_state     <= ACCESS;
                    end else if (if_req) begin
                        r_grantData <= 1'b0;
                        mem_en      <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= if_addr;
                        mem_wdata   <= '0;
                        r_count     <= 8'd0;
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
`ifdef MEM_PORT_STATS_EN
                    if (!mem_ready) begin
                        stat_wait <= stat_wait + 16'd1;
                    end
`endif
                    // A ready in the final watchdog cycle still counts as a real completion
                    if (mem_ready || (r_count == C_COUNT_LAST)) begin
                        if (!mem_we) begin
                            rdata <= mem_ready ? mem_rdata : '1;
                        end
                        if (!mem_ready) begin
                            timeout_err <= 1'b1;
                        end
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        if_done <= ~r_grantData;
                        d_done  <= r_grantData;
`ifdef MEM_PORT_STATS_EN
                        if (r_grantData) begin
                            stat_data <= stat_data + 16'd1;
                        end else begin
                            stat_fetches <= stat_fetches + 16'd1;
                        end
`endif
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (TIMEOUT=8): vector table,
// contention/reset sequences and randomized accesses against a reference model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_done;
    logic          d_done;
    logic [DW-1:0] rdata;
    logic          stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          timeout_err;
`ifdef MEM_PORT_STATS_EN
    logic [15:0]   stat_fetches;
    logic [15:0]   stat_data;
    logic [15:0]   stat_wait;
`endif

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .if_done     (if_done),
        .d_done      (d_done),
        .rdata       (rdata),
        .stall       (stall),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .timeout_err (timeout_err)
`ifdef MEM_PORT_STATS_EN
        ,
        .stat_fetches (stat_fetches),
        .stat_data    (stat_data),
        .stat_wait    (stat_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model of the architecturally visible state
    logic [DW-1:0] mRdata;
    bit            mErr;

    function automatic void check1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check16(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void checkInt(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Called on a falling edge while the DUT is idle; returns on the falling edge
    // of the IDLE cycle that follows DONE.
    task automatic runAccess(input bit isData, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] mdata,
                             input int waits, input logic [15:0] expRdata,
                             input bit expErr, input int expCycles);
        int acc;
        int cyc;
        bit done;
        bit otherReq;
        logic [15:0] expWdata;
        acc      = 0;
        cyc      = 0;
        done     = 1'b0;
        expWdata = we ? wdata : 16'h0000;
        if (isData) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        mem_rdata = mdata;
        mem_ready = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            otherReq = isData ? if_req : d_req;
            if (mem_en) begin
                check16("mem_addr", mem_addr, addr);
                check1("mem_we", mem_we, we);
                check16("mem_wdata", mem_wdata, expWdata);
                check1("stall_busy", stall, 1'b1);
                mem_ready = (acc == waits);
                acc++;
                // Moving the requester's inputs must not disturb the latched access
                if (isData) begin
                    d_addr = ~addr; d_wdata = ~wdata;
                end else begin
                    if_addr = ~addr;
                end
            end else begin
                mem_ready = 1'b0;
                if (isData ? d_done : if_done) begin
                    done = 1'b1;
                    check16("rdata", rdata, expRdata);
                    check1("timeout_err", timeout_err, expErr);
                    check1("other_done", isData ? if_done : d_done, 1'b0);
                    check1("stall_at_done", stall, otherReq);
                    checkInt("latency", cyc, expCycles + 1);
                    checkInt("access_cycles", acc, expCycles);
                    if (isData) d_req = 1'b0; else if_req = 1'b0;
                    #1;
                    check1("stall_after_drop", stall, otherReq);
                end else begin
                    check1("stall_wait", stall, 1'b1);
                end
            end
        end
        if (!done) begin
            checkInt("done_timeout", 0, 1);
            d_req = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
        end
        @(negedge clk);
        check1("idle_en", mem_en, 1'b0);
        check1("idle_done", if_done | d_done, 1'b0);
    endtask

    typedef struct {
        bit          isData;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdata;
        int          waits;
        logic [15:0] expRdata;
        bit          expErr;
        int          expCycles;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit          rIsData;
        bit          rWe;
        bit          rTimedOut;
        logic [15:0] rAddr;
        logic [15:0] rWdata;
        logic [15:0] rMdata;
        int          rWaits;
        int          rCycles;
        int          guard;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5C3, 0,  16'hA5C3, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'hDEAD, 3,  16'hA5C3, 1'b0, 4};
        vecs[2] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 16'h5A5A, 1,  16'h5A5A, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h1111, 20, 16'hFFFF, 1'b1, 8};
        vecs[4] = '{1'b0, 1'b0, 16'h0012, 16'h0000, 16'h0F0F, 0,  16'h0F0F, 1'b1, 1};
        vecs[5] = '{1'b1, 1'b1, 16'h0500, 16'hBEEF, 16'h2222, 7,  16'h0F0F, 1'b1, 8};
        vecs[6] = '{1'b1, 1'b1, 16'h0502, 16'hCAFE, 16'h3333, 8,  16'h0F0F, 1'b1, 8};

        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check1("rst_mem_en", mem_en, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check16("rst_mem_addr", mem_addr, 16'h0);
        check16("rst_mem_wdata", mem_wdata, 16'h0);
        check16("rst_rdata", rdata, 16'h0);
        check1("rst_done", if_done | d_done, 1'b0);
        check1("rst_err", timeout_err, 1'b0);
        check1("rst_stall", stall, 1'b0);
        reset = 1'b0;
        mRdata = 16'h0;
        mErr   = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            runAccess(vecs[i].isData, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mdata,
                      vecs[i].waits, vecs[i].expRdata, vecs[i].expErr, vecs[i].expCycles);
            mRdata = vecs[i].expRdata;
            mErr   = vecs[i].expErr;
        end

        // Both requests rise together: data first, then the held fetch
        if_req = 1'b1; if_addr = 16'h0040;
        runAccess(1'b1, 1'b0, 16'h0300, 16'h0000, 16'h7777, 2, 16'h7777, mErr, 3);
        runAccess(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h8888, 0, 16'h8888, mErr, 1);
        mRdata = 16'h8888;

        // Asynchronous reset in the second ACCESS cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0600; mem_ready = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!mem_en && guard < 10);
        check1("pre_rst_access", mem_en, 1'b1);
        @(negedge clk);
        check1("err_sticky", timeout_err, 1'b1);
        #2 reset = 1'b1;
        #1;
        check1("arst_mem_en", mem_en, 1'b0);
        check1("arst_done", if_done | d_done, 1'b0);
        check16("arst_rdata", rdata, 16'h0);
        check1("arst_err", timeout_err, 1'b0);
        @(negedge clk);
        reset = 1'b0; d_req = 1'b0;
        mRdata = 16'h0; mErr = 1'b0;
        runAccess(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1357, 1, 16'h1357, 1'b0, 2);
        mRdata = 16'h1357;

`ifdef MEM_PORT_STATS_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mRdata = 16'h0; mErr = 1'b0;
        runAccess(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0101, 0, 16'h0101, 1'b0, 1);
        runAccess(1'b0, 1'b0, 16'h0032, 16'h0000, 16'h0202, 0, 16'h0202, 1'b0, 1);
        runAccess(1'b1, 1'b0, 16'h0700, 16'h0000, 16'h0303, 2, 16'h0303, 1'b0, 3);
        mRdata = 16'h0303;
        check16("stat_fetches", stat_fetches, 16'd2);
        check16("stat_data", stat_data, 16'd1);
        check16("stat_wait", stat_wait, 16'd2);
`endif

        for (int n = 0; n < 40; n++) begin
            rIsData   = 1'($urandom_range(0, 1));
            rWe       = rIsData ? 1'($urandom_range(0, 1)) : 1'b0;
            rAddr     = 16'($urandom);
            rWdata    = 16'($urandom);
            rMdata    = 16'($urandom);
            rWaits    = int'($urandom_range(0, 10));
            rTimedOut = (rWaits >= TO);
            rCycles   = rTimedOut ? TO : rWaits + 1;
            if (!rWe) mRdata = rTimedOut ? 16'hFFFF : rMdata;
            mErr = mErr | rTimedOut;
            runAccess(rIsData, rWe, rAddr, rWdata, rMdata, rWaits, mRdata, mErr, rCycles);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
